// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: condition codes and
// bit positions within the NZCV flag register and the flag-write request.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction's
// condition field passes against a given {V,C,Z,N} flag set.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o,
  output logic       illegal_o
);

  logic  n, z, c, v;
  cond_e code;

  assign n    = flags_i[FLAG_N];
  assign z    = flags_i[FLAG_Z];
  assign c    = flags_i[FLAG_C];
  assign v    = flags_i[FLAG_V];
  assign code = cond_e'(cond_i);

  // NV is reserved: it never executes and is reported as illegal.
  always_comb begin
    cond_ex_o = 1'b0;
    illegal_o = 1'b0;
    case (code)
      EQ: cond_ex_o = z;
      NE: cond_ex_o = ~z;
      CS: cond_ex_o = c;
      CC: cond_ex_o = ~c;
      MI: cond_ex_o = n;
      PL: cond_ex_o = ~n;
      VS: cond_ex_o = v;
      VC: cond_ex_o = ~v;
      HI: cond_ex_o = c & ~z;
      LS: cond_ex_o = ~c | z;
      GE: cond_ex_o = (n == v);
      LT: cond_ex_o = (n != v);
      GT: cond_ex_o = ~z & (n == v);
      LE: cond_ex_o = z | (n != v);
      AL: cond_ex_o = 1'b1;
      NV: illegal_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: owns the architectural NZCV register, gates the
// write/branch controls by the condition and registers them for one stage.
module cond_unit
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic       stall_i,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  input  logic       pc_src_i,
  input  logic       no_write_i,
  output logic       valid_o,
  output logic       cond_ex_o,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       pc_src_o,
  output logic       illegal_o,
  output logic [3:0] flags_o
);

  logic [3:0] flags_q, flags_d;
  logic       valid_q, cond_ex_q, reg_write_q, mem_write_q, pc_src_q, illegal_q;
  logic       accept;
  logic       pass, illegal;

  cond_check u_check (
    .cond_i    (cond_i),
    .flags_i   (flags_q),
    .cond_ex_o (pass),
    .illegal_o (illegal)
  );

  assign accept = valid_i & ~stall_i;

  // Each flag group commits only for an accepted, executed instruction.
  always_comb begin
    flags_d = flags_q;
    if (accept && pass) begin
      if (flag_w_i[FW_NZ]) begin
        flags_d[FLAG_N] = alu_flags_i[FLAG_N];
        flags_d[FLAG_Z] = alu_flags_i[FLAG_Z];
      end
      if (flag_w_i[FW_CV]) begin
        flags_d[FLAG_C] = alu_flags_i[FLAG_C];
        flags_d[FLAG_V] = alu_flags_i[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      valid_q     <= 1'b0;
      cond_ex_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      pc_src_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (!stall_i) begin
      flags_q     <= flags_d;
      valid_q     <= valid_i;
      cond_ex_q   <= valid_i & pass;
      reg_write_q <= valid_i & pass & reg_w_i & ~no_write_i;
      mem_write_q <= valid_i & pass & mem_w_i;
      pc_src_q    <= valid_i & pass & pc_src_i;
      illegal_q   <= valid_i & illegal;
    end
  end

  assign valid_o     = valid_q;
  assign cond_ex_o   = cond_ex_q;
  assign reg_write_o = reg_write_q;
  assign mem_write_o = mem_write_q;
  assign pc_src_o    = pc_src_q;
  assign illegal_o   = illegal_q;
  assign flags_o     = flags_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_i = 1'b0, stall_i = 1'b0;
  logic [3:0] cond_i = 4'd0, alu_flags_i = 4'd0;
  logic [1:0] flag_w_i = 2'd0;
  logic       reg_w_i = 1'b0, mem_w_i = 1'b0, pc_src_i = 1'b0, no_write_i = 1'b0;
  logic       valid_o, cond_ex_o, reg_write_o, mem_write_o, pc_src_o, illegal_o;
  logic [3:0] flags_o;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;

  cond_unit dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .stall_i(stall_i),
    .cond_i(cond_i), .alu_flags_i(alu_flags_i), .flag_w_i(flag_w_i),
    .reg_w_i(reg_w_i), .mem_w_i(mem_w_i), .pc_src_i(pc_src_i),
    .no_write_i(no_write_i), .valid_o(valid_o), .cond_ex_o(cond_ex_o),
    .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
    .pc_src_o(pc_src_o), .illegal_o(illegal_o), .flags_o(flags_o)
  );

  always #5 clk = ~clk;

  // Reference: condition pairs share a predicate selected by cond[3:1],
  // with cond[0] inverting it; 1110 always passes, 1111 never does.
  function automatic bit condPass(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[0]; z = f[1]; c = f[2]; v = f[3];
    if (cond == 4'hE) return 1'b1;
    if (cond == 4'hF) return 1'b0;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b0;
    endcase
    return cond[0] ? !base : base;
  endfunction

  logic [3:0] expFlags;
  logic       expValid, expCond, expReg, expMem, expPc, expIll;

  always @(posedge clk) begin
    if (reset) begin
      expFlags <= 4'd0;
      expValid <= 0; expCond <= 0; expReg <= 0;
      expMem   <= 0; expPc   <= 0; expIll <= 0;
    end else if (!stall_i) begin
      automatic bit p = valid_i && condPass(cond_i, expFlags);
      expValid <= valid_i;
      expCond  <= p;
      expReg   <= p && reg_w_i && !no_write_i;
      expMem   <= p && mem_w_i;
      expPc    <= p && pc_src_i;
      expIll   <= valid_i && (cond_i == 4'hF);
      if (p) expFlags <= {flag_w_i[0] ? alu_flags_i[3:2] : expFlags[3:2],
                          flag_w_i[1] ? alu_flags_i[1:0] : expFlags[1:0]};
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("valid_o",     {3'b0, valid_o},     {3'b0, expValid});
      checkOutput("cond_ex_o",   {3'b0, cond_ex_o},   {3'b0, expCond});
      checkOutput("reg_write_o", {3'b0, reg_write_o}, {3'b0, expReg});
      checkOutput("mem_write_o", {3'b0, mem_write_o}, {3'b0, expMem});
      checkOutput("pc_src_o",    {3'b0, pc_src_o},    {3'b0, expPc});
      checkOutput("illegal_o",   {3'b0, illegal_o},   {3'b0, expIll});
      checkOutput("flags_o",     flags_o,             expFlags);
    end
  end

  // Drives one cycle of inputs at the falling edge and returns just after the
  // capturing rising edge, so the registered result is then visible.
  task automatic applyStimulus(input bit rst, input bit vld, input bit stl,
                               input logic [3:0] cond, input logic [3:0] alu,
                               input logic [1:0] fw, input bit rw, input bit mw,
                               input bit pc, input bit nw);
    @(negedge clk);
    reset = rst; valid_i = vld; stall_i = stl; cond_i = cond;
    alu_flags_i = alu; flag_w_i = fw; reg_w_i = rw; mem_w_i = mw;
    pc_src_i = pc; no_write_i = nw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
    checkEn = 1'b1;
    applyStimulus(1, 1, 0, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0);
    checkOutput("rst_valid", {3'b0, valid_o}, 4'h0);
    checkOutput("rst_flags", flags_o, 4'h0);

    applyStimulus(0, 1, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);
    checkOutput("eq0_condex", {3'b0, cond_ex_o}, 4'h0);
    checkOutput("eq0_regw", {3'b0, reg_write_o}, 4'h0);
    checkOutput("eq0_flags", flags_o, 4'h0);

    applyStimulus(0, 1, 0, 4'hE, 4'b0010, 2'b11, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);
    checkOutput("eq1_condex", {3'b0, cond_ex_o}, 4'h1);
    checkOutput("eq1_regw", {3'b0, reg_write_o}, 4'h1);
    checkOutput("eq1_flags", flags_o, 4'b0010);

    applyStimulus(0, 1, 0, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 4'hA, 4'h0, 2'b00, 0, 1, 0, 0);
    checkOutput("ge_condex", {3'b0, cond_ex_o}, 4'h0);
    checkOutput("ge_memw", {3'b0, mem_write_o}, 4'h0);
    applyStimulus(0, 1, 0, 4'hB, 4'h0, 2'b00, 0, 1, 0, 0);
    checkOutput("lt_condex", {3'b0, cond_ex_o}, 4'h1);
    checkOutput("lt_memw", {3'b0, mem_write_o}, 4'h1);

    applyStimulus(0, 1, 0, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 4'hE, 4'b0000, 2'b10, 0, 0, 0, 0);
    checkOutput("nz_only_flags", flags_o, 4'b1100);

    applyStimulus(0, 1, 0, 4'hF, 4'b0011, 2'b11, 0, 0, 1, 0);
    checkOutput("nv_illegal", {3'b0, illegal_o}, 4'h1);
    checkOutput("nv_pcsrc", {3'b0, pc_src_o}, 4'h0);
    checkOutput("nv_flags", flags_o, 4'b1100);

    applyStimulus(0, 1, 0, 4'hE, 4'b0101, 2'b11, 1, 0, 0, 0);
    checkOutput("pre_stall_flags", flags_o, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 4'hE, 4'b1010, 2'b11, 0, 1, 1, 0);
      checkOutput("stall_valid", {3'b0, valid_o}, 4'h1);
      checkOutput("stall_regw", {3'b0, reg_write_o}, 4'h1);
      checkOutput("stall_memw", {3'b0, mem_write_o}, 4'h0);
      checkOutput("stall_flags", flags_o, 4'b0101);
    end
    applyStimulus(1, 1, 1, 4'hE, 4'b1010, 2'b11, 1, 1, 1, 0);
    checkOutput("stall_rst_valid", {3'b0, valid_o}, 4'h0);
    checkOutput("stall_rst_regw", {3'b0, reg_write_o}, 4'h0);
    checkOutput("stall_rst_flags", flags_o, 4'h0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) == 0),
                    4'($urandom), 4'($urandom), 2'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
